// File: rtl/arb_pipe_ctrl.sv
// arb_pipe_ctrl: two-requester round-robin arbiter feeding a two-stage stallable, flushable pipeline.
// Define ARB_PIPE_SANITIZE_EN to zero stage data whenever a stage holds no valid entry.
module arb_pipe_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);
   logic             s1_valid, s1_src, s2_valid, s2_src, last;
   logic [WIDTH-1:0] s1_data, s2_data;
   logic             s2_adv, s1_adv, can_gnt, gnt0, gnt1;

   // last holds the previously granted requester; reset to 1 so requester 0 wins first contention
   always_comb begin
      s2_adv  = !s2_valid || out_ready;
      s1_adv  = !s1_valid || s2_adv;
      can_gnt = rst_n && !flush && s1_adv;
      gnt0    = can_gnt && req0_valid && (!req1_valid || last);
      gnt1    = can_gnt && req1_valid && (!req0_valid || !last);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign out_valid  = s2_valid;
   assign out_data   = s2_data;
   assign out_src    = s2_src;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_data  <= '0;
         s2_data  <= '0;
         s1_src   <= 1'b0;
         s2_src   <= 1'b0;
         last     <= 1'b1;
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
`ifdef ARB_PIPE_SANITIZE_EN
         s1_data  <= '0;
         s2_data  <= '0;
`endif
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_data;
               s2_src  <= s1_src;
            end
`ifdef ARB_PIPE_SANITIZE_EN
            else s2_data <= '0;
`endif
         end
         if (s1_adv) begin
            s1_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
               s1_data <= gnt1 ? req1_data : req0_data;
               s1_src  <= gnt1;
               last    <= gnt1;
            end
`ifdef ARB_PIPE_SANITIZE_EN
            else s1_data <= '0;
`endif
         end
         if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
         if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
   end
endmodule

// File: tb/tb_arb_pipe_ctrl.sv
// tb_arb_pipe_ctrl: directed stimulus with a queue scoreboard; a forked monitor pops on each output handshake.
module tb_arb_pipe_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
   logic             req0_ready, req1_ready, out_valid, out_src;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

   int checks = 0;
   int errors = 0;
   logic [WIDTH:0] sb[$];

   always #5 clk = ~clk;

   arb_pipe_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic src, input logic [WIDTH-1:0] d);
      sb.push_back({src, d});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      #1;
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_cnt0", 32'(gnt_cnt0), 0);
      chk("rst_cnt1", 32'(gnt_cnt1), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] t3_rdy;
      logic [WIDTH-1:0] t3_dat[6];
      logic [5:0] t3_or;
      logic [WIDTH-1:0] retain_exp;
      fork
         forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
               if (sb.size() == 0) chk("mon_unexpected_entry", {23'd0, out_src, out_data}, 32'h1ff);
               else chk("mon_entry", {23'd0, out_src, out_data}, 32'(sb.pop_front()));
            end
         end
      join_none

      do_reset();

      // single payload, two-cycle latency
      req0_valid = 1'b1; req0_data = 8'h11; out_ready = 1'b1;
      #1;
      chk("t1_ready0", 32'(req0_ready), 1);
      chk("t1_ready1", 32'(req1_ready), 0);
      push(1'b0, 8'h11);
      step();
      req0_valid = 1'b0;
      #1;
      chk("t1_lat1_valid", 32'(out_valid), 0);
      step();
      chk("t1_out_valid", 32'(out_valid), 1);
      chk("t1_out_data", 32'(out_data), 32'h11);
      chk("t1_out_src", 32'(out_src), 0);
      chk("t1_cnt0", 32'(gnt_cnt0), 1);
      step();

      // round-robin under continuous contention
      do_reset();
      req0_data = 8'hA0; req1_data = 8'hB1; out_ready = 1'b1;
      push(0, 8'hA0); push(1, 8'hB1); push(0, 8'hA0); push(1, 8'hB1);
      for (int k = 0; k < 7; k++) begin
         req0_valid = (k < 4);
         req1_valid = (k < 4);
         #1;
         if (k < 4) begin
            chk($sformatf("t2_ready0_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
            chk($sformatf("t2_ready1_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
         end
         chk($sformatf("t2_out_valid_%0d", k), 32'(out_valid), 32'(k >= 2 && k <= 5));
         step();
      end
      chk("t2_cnt0", 32'(gnt_cnt0), 2);
      chk("t2_cnt1", 32'(gnt_cnt1), 2);

      // stall: out_ready low for three cycles
      t3_rdy = 6'b100011;
      t3_or  = 6'b100011;
      t3_dat = '{8'h50, 8'h51, 8'h52, 8'h52, 8'h52, 8'h52};
      push(0, 8'h50); push(0, 8'h51); push(0, 8'h52);
      for (int k = 0; k < 6; k++) begin
         req0_valid = 1'b1;
         req0_data = t3_dat[k];
         out_ready = t3_or[k];
         #1;
         chk($sformatf("t3_ready0_%0d", k), 32'(req0_ready), 32'(t3_rdy[k]));
         if (k >= 2) begin
            chk($sformatf("t3_frozen_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("t3_frozen_data_%0d", k), 32'(out_data), 32'h50);
         end
         step();
      end
      req0_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      chk("t3_drained", 32'(sb.size()), 0);
      chk("t3_cnt0", 32'(gnt_cnt0), 5);

      // flush with both stages full
      out_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 8'hC1;
      #1;
      chk("t4_fill_ready1", 32'(req1_ready), 1);
      step();
      req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'hC0;
      #1;
      chk("t4_fill_ready0", 32'(req0_ready), 1);
      step();
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hE0; req1_data = 8'hD1;
      out_ready = 1'b1; flush = 1'b1;
      #1;
      chk("t4_flush_ready0", 32'(req0_ready), 0);
      chk("t4_flush_ready1", 32'(req1_ready), 0);
      chk("t4_full_valid", 32'(out_valid), 1);
      chk("t4_full_data", 32'(out_data), 32'hC1);
      step();
      flush = 1'b0;
      #1;
      chk("t4_post_valid", 32'(out_valid), 0);
      chk("t4_post_cnt0", 32'(gnt_cnt0), 6);
      chk("t4_post_cnt1", 32'(gnt_cnt1), 3);
      chk("t4_rr_ready0", 32'(req0_ready), 0);
      chk("t4_rr_ready1", 32'(req1_ready), 1);
      push(1, 8'hD1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) step();
      chk("t4_drained", 32'(sb.size()), 0);

      // idle output data: sanitized or stale
`ifdef ARB_PIPE_SANITIZE_EN
      retain_exp = 8'h00;
`else
      retain_exp = 8'hD1;
`endif
      chk("t5_idle_valid", 32'(out_valid), 0);
      chk("t5_idle_data", 32'(out_data), 32'(retain_exp));

      // reset mid-transfer discards the in-flight entry
      req0_valid = 1'b1; req0_data = 8'h99;
      step();
      req0_valid = 1'b0;
      do_reset();
      step();
      chk("t6_discard_valid", 32'(out_valid), 0);

      // counter saturation
      req0_valid = 1'b1; req0_data = 8'h77; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 10) chk("t7_cnt0_mid", 32'(gnt_cnt0), 10);
         push(0, 8'h77);
         step();
      end
      req0_valid = 1'b0;
      #1;
      chk("t7_cnt0_sat", 32'(gnt_cnt0), 15);
      chk("t7_cnt1", 32'(gnt_cnt1), 0);
      repeat (3) step();
      chk("t7_drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/arb_pipe_ctrl.md
ARB_PIPE_CTRL -- requirements
Module: arb_pipe_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of both requester payloads and the output.
REQ-002 SHALL have parameter: CNT_W, 4, width of each saturating per-requester grant counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port: req0_valid  input  1  requester 0 presents a payload.
REQ-006 SHALL have port: req0_data  input  WIDTH  requester 0 payload.
REQ-007 SHALL have port: req0_ready  output  1  requester 0 payload accepted this cycle.
REQ-008 SHALL have port: req1_valid  input  1  requester 1 presents a payload.
REQ-009 SHALL have port: req1_data  input  WIDTH  requester 1 payload.
REQ-010 SHALL have port: req1_ready  output  1  requester 1 payload accepted this cycle.
REQ-011 SHALL have port: flush  input  1  invalidates all in-flight pipeline entries.
REQ-012 SHALL have port: out_valid  output  1  out_data/out_src hold a valid entry.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts the output entry.
REQ-014 SHALL have port: out_data  output  WIDTH  payload at pipeline output.
REQ-015 SHALL have port: out_src  output  1  index of the requester that produced out_data.
REQ-016 SHALL have port: gnt_cnt0, gnt_cnt1  output  CNT_W  saturating accepted-payload counts per requester.

Function
REQ-017 SHALL grant at most one requester per cycle; reqN_ready combinational from valids, rr pointer and stall.
REQ-018 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; single valid is granted directly.
REQ-019 SHALL update the round-robin pointer only on an accepted grant (valid && ready).
REQ-020 SHALL carry each accepted payload through two register stages (S1, S2); S2 drives out_*; accept-to-out_valid latency 2 cycles when unstalled.
REQ-021 SHALL stall: S2 holds while out_valid && !out_ready; S1 advances only if S2 empty or draining; no grant while S1 occupied and cannot advance.
REQ-022 SHALL sustain one payload per cycle when out_ready stays high; no entry dropped or duplicated under any out_ready pattern.
REQ-023 SHALL derive grant decisions only from valid, ready, flush and pipeline occupancy, never from payload values.
REQ-024 SHALL, on flush, clear S1 and S2 valid bits next cycle, assert no reqN_ready in the flush cycle, and leave rr pointer and counters unchanged.
REQ-025 SHALL increment gnt_cntN on each accepted grant of requester N, saturating at 2^CNT_W-1 (no wrap).
REQ-026 SHALL give flush priority over a simultaneous grant and a simultaneous out_ready handshake (entry discarded, not delivered).

Reset
REQ-027 SHALL, with rst_n low at a rising edge, clear S1/S2 valid, out_valid=0, out_data=0, out_src=0, gnt_cnt0=gnt_cnt1=0, rr pointer so requester 0 wins the first contention.
REQ-028 SHALL hold req0_ready=req1_ready=0 while rst_n is low; reset mid-transfer discards all in-flight entries.

Configuration
REQ-029 SHALL support macro ARB_PIPE_SANITIZE_EN: when defined, S1/S2 data registers load 0 whenever their valid bit is cleared (idle, flush, reset), so out_data=0 whenever out_valid=0.
REQ-030 SHALL, without ARB_PIPE_SANITIZE_EN, leave data registers holding stale payloads when invalid; only valid bits cleared.

Verification
REQ-031 SHALL cover: reset, then req0_valid=1 data 0x11 one cycle, out_ready=1 -> out_valid=1, out_data=0x11, out_src=0 two cycles later, gnt_cnt0=1.
REQ-032 SHALL cover: both valid continuously, data0=0xA0, data1=0xB1, out_ready=1 -> out_src sequence 0,1,0,1, one entry per cycle.
REQ-033 SHALL cover: stream then out_ready=0 for 3 cycles -> out_data frozen, reqN_ready=0 after S1 fills, no loss on release.
REQ-034 SHALL cover: flush with S1 and S2 full -> out_valid=0 next cycle, counters unchanged, next grant resumes rr order.
REQ-035 SHALL cover: 20 grants to requester 0 with CNT_W=4 -> gnt_cnt0 saturates at 15.
REQ-036 SHALL cover: with ARB_PIPE_SANITIZE_EN, after drain out_data=0; without it, out_data retains last payload.
